// File: rtl/program_loader.sv
// -----------------------------------------------------------------------------
// program_loader
//
// Streams a program into instruction memory. A load is a little-endian byte
// stream: a 16-bit word count (low byte first) followed by that many 32-bit
// instruction words, each sent least-significant byte first. Each assembled
// word is written to the next word address, starting at 0. The CPU is held
// for the whole load. When idle, the loader is transparent: the CPU program
// counter drives the memory address and writes are disabled.
//
// Ports
//   clk               system clock, rising edge
//   reset             asynchronous, active-high; returns to IDLE at once
//   load_start        one-cycle request to begin a load (seen only in IDLE)
//   byte_data[7:0]    stream byte
//   byte_valid        byte_data holds a valid byte
//   byte_ready        loader accepts a byte this cycle
//   cpu_pc[31:0]      CPU fetch byte address
//   cpu_hold          CPU must stall (any state other than IDLE)
//   mem_byte_address  byte address to instruction memory
//   mem_write_enable  instruction memory write strobe
//   mem_write_data    word to write
//   load_done         one-cycle pulse, load completed
//   load_error        one-cycle pulse, length header rejected
// -----------------------------------------------------------------------------
module program_loader #(
  parameter int MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_start,
  input  logic [7:0]  byte_data,
  input  logic        byte_valid,
  output logic        byte_ready,
  input  logic [31:0] cpu_pc,
  output logic        cpu_hold,
  output logic [31:0] mem_byte_address,
  output logic        mem_write_enable,
  output logic [31:0] mem_write_data,
  output logic        load_done,
  output logic        load_error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERROR
  } state_t;

  state_t      r_state;
  state_t      w_next_state;

  logic [8:0]  r_word_index;   // 9 bits: must be able to reach MAX_WORDS
  logic [1:0]  r_byte_count;   // byte lane within the word being assembled
  logic [15:0] r_length;
  logic [31:0] r_word;

  logic        w_handshake;
  logic [15:0] w_len_full;
  logic        w_len_ok;
  logic [8:0]  w_index_next;
  logic        w_last_word;

  assign w_handshake  = byte_valid && byte_ready;
  // The high length byte is still on the bus in LEN_HI, so the range check
  // uses it directly rather than waiting a cycle for r_length to update.
  assign w_len_full   = {byte_data, r_length[7:0]};
  assign w_len_ok     = (w_len_full != 16'd0) && (w_len_full <= 16'(MAX_WORDS));
  assign w_index_next = r_word_index + 9'd1;
  assign w_last_word  = ({7'd0, w_index_next} == r_length);

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic.
  // NOTE: default assigned first so every path drives w_next_state and no
  // latch is inferred.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE:   if (load_start) w_next_state = S_LEN_LO;
      S_LEN_LO: if (w_handshake) w_next_state = S_LEN_HI;
      S_LEN_HI: if (w_handshake) w_next_state = w_len_ok ? S_DATA : S_ERROR;
      S_DATA:   if (w_handshake && (r_byte_count == 2'd3)) w_next_state = S_WRITE;
      S_WRITE:  w_next_state = w_last_word ? S_DONE : S_DATA;
      S_DONE:   w_next_state = S_IDLE;
      S_ERROR:  w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // Outputs decoded from the state register only, so they are glitch-free
  // and drop to their reset values the instant reset asserts.
  always_comb begin
    byte_ready       = 1'b0;
    mem_write_enable = 1'b0;
    load_done        = 1'b0;
    load_error       = 1'b0;
    cpu_hold         = (r_state != S_IDLE);
    unique case (r_state)
      S_LEN_LO, S_LEN_HI, S_DATA: byte_ready       = 1'b1;
      S_WRITE:                    mem_write_enable = 1'b1;
      S_DONE:                     load_done        = 1'b1;
      S_ERROR:                    load_error       = 1'b1;
      default: ;
    endcase
  end

  // The address mux is the one combinational path: the CPU sees memory
  // directly whenever no load is in progress.
  assign mem_byte_address = (r_state == S_IDLE) ? cpu_pc
                                                : {21'd0, r_word_index, 2'b00};
  assign mem_write_data   = r_word;

  // Datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_word_index <= 9'd0;
      r_byte_count <= 2'd0;
      r_length     <= 16'd0;
      r_word       <= 32'd0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (load_start) begin
            r_word_index <= 9'd0;
            r_byte_count <= 2'd0;
            r_length     <= 16'd0;
          end
        end
        S_LEN_LO: if (w_handshake) r_length[7:0]  <= byte_data;
        S_LEN_HI: if (w_handshake) r_length[15:8] <= byte_data;
        S_DATA: begin
          if (w_handshake) begin
            r_word[{r_byte_count, 3'b000} +: 8] <= byte_data;
            r_byte_count <= r_byte_count + 2'd1;
          end
        end
        S_WRITE: r_word_index <= w_index_next;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/program_loader.md
# program_loader

Sequencing controller that owns the write port of the instruction memory and shares its address port with the CPU fetch path. On command it accepts a little-endian byte stream (length header followed by instruction words), assembles 32-bit words, writes them to consecutive word addresses starting at 0, and holds the CPU for the whole load. When idle it is transparent: the CPU program counter drives the memory address and writes are disabled.

## Interface
- MAX_WORDS, 256: memory depth in words; largest accepted length.
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-high; forces IDLE immediately.
- load_start  input  1  single-cycle request to begin a load; sampled only in IDLE.
- byte_data  input  8  stream byte.
- byte_valid  input  1  byte_data holds a valid byte.
- byte_ready  output  1  loader can accept a byte this cycle.
- cpu_pc  input  32  CPU fetch byte address.
- cpu_hold  output  1  CPU must stall; high whenever state is not IDLE.
- mem_byte_address  output  32  byte address to instruction memory.
- mem_write_enable  output  1  instruction memory write strobe.
- mem_write_data  output  32  word to write.
- load_done  output  1  one-cycle pulse, load completed successfully.
- load_error  output  1  one-cycle pulse, length header rejected.

## Operation
- States: IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE, ERROR.
- IDLE: load_start=1 -> LEN_LO; word_index, byte_count, length cleared.
- LEN_LO: on handshake length[7:0]=byte_data -> LEN_HI.
- LEN_HI: on handshake length[15:8]=byte_data; next state DATA if 1 <= {byte_data,length[7:0]} <= MAX_WORDS, else ERROR.
- DATA: on handshake byte stored in lane byte_count (byte 0 -> word[7:0], byte 3 -> word[31:24]); byte_count (2 bits) increments; on 4th byte -> WRITE.
- WRITE: mem_write_enable=1, mem_write_data=assembled word, address = word_index*4; word_index increments (9-bit counter); if incremented value == length -> DONE, else DATA.
- DONE: load_done=1 -> IDLE. ERROR: load_error=1 -> IDLE. No memory writes ever occur on an error path.
- Handshake: byte accepted on rising edge where byte_valid && byte_ready. byte_ready=1 only in LEN_LO, LEN_HI, DATA; 0 in all other states. byte_data ignored without handshake; stalls of any length on byte_valid are legal.
- Address mux (combinational): IDLE -> mem_byte_address = cpu_pc; otherwise {21'b0, word_index, 2'b00}.
- mem_write_data = assembled word register (don't-care outside WRITE but must be deterministic, reset to 0).
- load_start outside IDLE ignored. Stream bytes arriving after the last word are not consumed (byte_ready=0 from WRITE onward).

## Timing
- Reset values: state IDLE, byte_ready 0, cpu_hold 0, mem_write_enable 0, mem_write_data 0, load_done 0, load_error 0, all counters 0; mem_byte_address follows cpu_pc.
- Reset mid-load: aborts immediately; no write strobe after reset asserts; words already written remain in memory; no done/error pulse.
- cpu_hold rises the cycle after load_start is sampled in IDLE, falls the cycle after DONE/ERROR.
- All outputs registered/state-decoded except mem_byte_address (mux on cpu_pc).
- Latency with byte_valid held high: load_start cycle + 2 header cycles + 5 cycles per word (4 DATA + 1 WRITE) + 1 DONE; N words -> cpu_hold high for 3 + 5N cycles.
- Minimum spacing between writes: 5 cycles.

## Test plan
- Load N=2, bytes 02 00 13 05 10 00 93 05 20 00 with continuous valid -> writes 0x00100513 @0x0, 0x00200593 @0x4; load_done pulses; cpu_hold high exactly 13 cycles.
- Same load with byte_valid low every other cycle -> identical writes, no byte lost or duplicated, byte_ready low in WRITE.
- Header 00 00 and header 01 01 (257) -> load_error one pulse, zero mem_write_enable, back to IDLE, cpu_hold low.
- N=256 full load -> last write at address 0x3FC, word_index reaches 256, load_done pulse.
- Idle passthrough: cpu_pc=0x0000_0040 -> mem_byte_address 0x40, mem_write_enable 0; load_start during DATA ignored.
- Assert reset after 6 data bytes of N=3 -> only word 0 written, all outputs at reset values within same cycle, new load then succeeds.
